// File: rtl/data_mem_responder.sv
// Data-memory responder: serves CPU byte/half/word load/store requests over valid/ready handshakes.
// Response WAIT_CYCLES+1 cycles after accept; one request in flight, req_ready low until response taken.
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_width,
    input  logic        req_sign,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  waitCnt;
    logic        latWrite;
    logic [31:0] latAddr;
    logic [31:0] latWdata;
    logic [1:0]  latWidth;
    logic        latSign;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          doAccess;
    logic          curWrite;
    logic [31:0]   curAddr;
    logic [31:0]   curWdata;
    logic [1:0]    curWidth;
    logic          curSign;
    logic          accErr;
    logic [AW-1:0] wordIdx;
    logic [31:0]   rdWord;
    logic [31:0]   loadData;
    logic [31:0]   wrData;
    logic [3:0]    byteEn;
    logic [7:0]    selByte;
    logic [15:0]   selHalf;

    assign accept = (state == IDLE) && req_valid && req_ready;

    // With zero wait states the access happens on the accept edge, before anything is latched.
    always_comb begin
        curWrite = latWrite;
        curAddr  = latAddr;
        curWdata = latWdata;
        curWidth = latWidth;
        curSign  = latSign;
        if (state == IDLE) begin
            curWrite = req_write;
            curAddr  = req_addr;
            curWdata = req_wdata;
            curWidth = req_width;
            curSign  = req_sign;
        end
    end

    assign doAccess = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (waitCnt == 4'd0));

    // BASE_ADDR is aligned to the array size, so the range check is a compare of the upper bits.
    assign accErr = (curWidth == 2'b11)
                 || ((curWidth == 2'b01) && curAddr[0])
                 || ((curWidth == 2'b10) && (curAddr[1:0] != 2'b00))
                 || (curAddr[31:AW+2] != BASE_ADDR[31:AW+2]);

    assign wordIdx = curAddr[AW+1:2];
    assign rdWord  = mem[wordIdx];
    assign selByte = rdWord[8*curAddr[1:0] +: 8];
    assign selHalf = rdWord[16*curAddr[1] +: 16];

    always_comb begin
        loadData = rdWord;
        wrData   = curWdata;
        byteEn   = 4'b1111;
        case (curWidth)
            2'b00: begin
                loadData = {{24{curSign & selByte[7]}}, selByte};
                wrData   = {4{curWdata[7:0]}};
                byteEn   = 4'b0001 << curAddr[1:0];
            end
            2'b01: begin
                loadData = {{16{curSign & selHalf[15]}}, selHalf};
                wrData   = {2{curWdata[15:0]}};
                byteEn   = curAddr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (doAccess && !accErr && curWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) mem[wordIdx][8*b +: 8] <= wrData[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            waitCnt   <= 4'd0;
            latWrite  <= 1'b0;
            latAddr   <= 32'h0;
            latWdata  <= 32'h0;
            latWidth  <= 2'b00;
            latSign   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        latWrite  <= req_write;
                        latAddr   <= req_addr;
                        latWdata  <= req_wdata;
                        latWidth  <= req_width;
                        latSign   <= req_sign;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES > 0) begin
                            state   <= WAIT;
                            waitCnt <= 4'(WAIT_CYCLES - 1);
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= accErr;
                            rsp_rdata <= (accErr || curWrite) ? 32'h0 : loadData;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (waitCnt == 4'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= accErr;
                        rsp_rdata <= (accErr || curWrite) ? 32'h0 : loadData;
                    end else begin
                        waitCnt <= waitCnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
